// File: rtl/store_align_unit.sv
// store_align_unit: translates pipeline stores into word-aligned, lane-enabled
// data-memory writes and buffers up to two of them in a small FIFO.
// Reserved-size stores raise a one-cycle address-error pulse (ades) and record
// the faulting address in badvaddr.
// Optional feature macro: STORE_ALIGN_EXC_EN
//   defined   -> misaligned halfword/word stores are dropped and raise ades
//   undefined -> misaligned offsets are forced aligned and the store proceeds
module store_align_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        dm_req,
  input  logic        dm_ack,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wen,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        empty
);

`ifdef STORE_ALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // FIFO storage and pointers
  logic [31:0] addr_q [2];
  logic [31:0] addr_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [3:0]  wen_q  [2];
  logic [3:0]  wen_d  [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        ades_q, ades_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  // Translation results for the request currently on the st_* inputs
  logic [31:0] tr_addr;
  logic [31:0] tr_data;
  logic [3:0]  tr_wen;
  logic        reserved;
  logic        misalign;
  logic        fault;
  logic        accept;
  logic        push;
  logic        pop;

  assign st_ready = !rst && (count_q < 2'd2);
  assign dm_req   = (count_q != 2'd0);
  assign empty    = (count_q == 2'd0);
  assign ades     = ades_q;
  assign badvaddr = badvaddr_q;

  // Head of FIFO is presented only while a write is pending; idle bus reads zero
  assign dm_addr  = dm_req ? addr_q[rd_ptr_q] : 32'd0;
  assign dm_wdata = dm_req ? data_q[rd_ptr_q] : 32'd0;
  assign dm_wen   = dm_req ? wen_q[rd_ptr_q]  : 4'd0;

  // Size/offset decode into lane-replicated data and byte enables
  always_comb begin
    tr_addr  = {st_addr[31:2], 2'b00};
    tr_data  = st_data;
    tr_wen   = 4'b1111;
    reserved = 1'b0;
    misalign = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        tr_data = {4{st_data[7:0]}};
        tr_wen  = 4'b0001 << st_addr[1:0];
      end
      SZ_HALF: begin
        // bit 0 of the offset is ignored for lane selection
        tr_data  = {2{st_data[15:0]}};
        tr_wen   = st_addr[1] ? 4'b1100 : 4'b0011;
        misalign = st_addr[0];
      end
      SZ_WORD: begin
        tr_data  = st_data;
        tr_wen   = 4'b1111;
        misalign = (st_addr[1:0] != 2'b00);
      end
      default: begin
        reserved = 1'b1;
      end
    endcase
    fault = reserved || (EXC_EN && misalign);
  end

  assign accept = st_valid && st_ready;
  assign push   = accept && !fault;
  // An ack with nothing pending is ignored; reset overrides any ack
  assign pop    = dm_req && dm_ack;

  // Next-state for FIFO contents, pointers, occupancy and error reporting
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    wen_d      = wen_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ades_d     = accept && fault;
    badvaddr_d = badvaddr_q;

    if (push) begin
      addr_d[wr_ptr_q] = tr_addr;
      data_d[wr_ptr_q] = tr_data;
      wen_d[wr_ptr_q]  = tr_wen;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (accept && fault) begin
      badvaddr_d = st_addr;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= 32'd0;
        data_q[i] <= 32'd0;
        wen_q[i]  <= 4'd0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ades_q     <= 1'b0;
      badvaddr_q <= 32'd0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ades_q     <= ades_d;
      badvaddr_q <= badvaddr_d;
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: a driver issues directed then random
// stores and pushes the expected memory writes into a queue; a monitor pops and
// compares whenever a write is acknowledged.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        dm_req;
  logic        dm_ack;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wen;
  logic        ades;
  logic [31:0] badvaddr;
  logic        empty;

  always #5 clk = ~clk;

  store_align_unit dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_size  (st_size),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .dm_req   (dm_req),
    .dm_ack   (dm_ack),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wen   (dm_wen),
    .ades     (ades),
    .badvaddr (badvaddr),
    .empty    (empty)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } wr_t;

  wr_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        exp_ades = 1'b0;
  logic [31:0] exp_bv = 32'd0;
  bit          model_valid = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference translation straight from the size/offset rules
  function automatic void ref_xlate(input logic [1:0] sz, input logic [31:0] a,
                                    input logic [31:0] d, output wr_t e, output bit f);
    int unsigned off;
    off = a % 4;
    f = (sz == 2'd3);
`ifdef STORE_ALIGN_EXC_EN
    if (sz == 2'd1 && (off % 2) != 0) f = 1'b1;
    if (sz == 2'd2 && off != 0) f = 1'b1;
`endif
    e.a = a - off;
    e.d = d;
    e.w = 4'hF;
    if (sz == 2'd0) begin
      e.d = (d & 32'hFF) * 32'h0101_0101;
      e.w = 4'(1 << off);
    end else if (sz == 2'd1) begin
      e.d = (d & 32'hFFFF) * 32'h0001_0001;
      e.w = (off >= 2) ? 4'hC : 4'h3;
    end
  endfunction

  // One clock of stimulus; model is updated after the edge that consumes it
  task automatic drive(input bit v, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit ack, input bit r);
    wr_t e;
    bit  f;
    bit  acc;
    st_valid = v;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    dm_ack   = ack;
    rst      = r;
    #1;
    if (model_valid)
      check("st_ready", 32'(st_ready), 32'((!r && exp_q.size() < 2) ? 1 : 0));
    acc = v && st_ready;
    ref_xlate(sz, a, d, e, f);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_ades    = 1'b0;
      exp_bv      = 32'd0;
      model_valid = 1'b1;
    end else begin
      exp_ades = acc && f;
      if (acc && f) exp_bv = a;
      if (acc && !f) exp_q.push_back(e);
    end
  endtask

  task automatic idle(input bit ack);
    drive(1'b0, 2'd0, 32'd0, 32'd0, ack, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1'b1);
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d writes still expected", exp_q.size());
    end
  endtask

  // Monitor: compares acknowledged writes and status outputs each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid && !rst) begin
        check("empty", 32'(empty), 32'((exp_q.size() == 0) ? 1 : 0));
        check("dm_req", 32'(dm_req), 32'((exp_q.size() != 0) ? 1 : 0));
        check("ades", 32'(ades), 32'(exp_ades));
        check("badvaddr", badvaddr, exp_bv);
        if (exp_q.size() == 0) begin
          check("idle_wen", 32'(dm_wen), 32'd0);
          check("idle_addr", dm_addr, 32'd0);
        end
        if (dm_req && dm_ack) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_write: addr %h with nothing expected", dm_addr);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("dm_addr", dm_addr, e.a);
            check("dm_wdata", dm_wdata, e.d);
            check("dm_wen", 32'(dm_wen), 32'(e.w));
          end
        end
      end
    end
  end

  initial begin
    st_valid = 1'b0;
    st_size  = 2'd0;
    st_addr  = 32'd0;
    st_data  = 32'd0;
    dm_ack   = 1'b0;
    rst      = 1'b1;

    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(1'b0);

    // byte at offset 3, then halfword at upper half
    drive(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 1'b0, 1'b0);
    idle(1'b0);
    drain();
    drive(1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 1'b0);
    drain();

    // three back-to-back words with ack held low: third is refused
    drive(1'b1, 2'd2, 32'h0000_0100, 32'h1111_1111, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'h0000_0104, 32'h2222_2222, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'h0000_0108, 32'h3333_3333, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // simultaneous accept and pop
    drive(1'b1, 2'd2, 32'h0000_0200, 32'hAAAA_0001, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'h0000_0204, 32'hAAAA_0002, 1'b1, 1'b0);
    drive(1'b1, 2'd0, 32'h0000_0209, 32'hAAAA_0033, 1'b1, 1'b0);
    drain();

    // misaligned word: behaviour depends on the exception macro
    drive(1'b1, 2'd2, 32'h0000_3001, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // reserved size, then back-to-back faults
    drive(1'b1, 2'd3, 32'h0000_4444, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 32'h0000_5555, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 32'h0000_6667, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // ack on an empty unit is ignored
    idle(1'b1);

    // reset with two entries pending and ack high
    drive(1'b1, 2'd2, 32'h0000_7000, 32'h7777_0000, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'h0000_7004, 32'h7777_0004, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
            ($urandom % 2) != 0, ($urandom % 64) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
